// File: rtl/rf_master_pkg.sv
// Shared types and constants for the register-file access master.
// State encoding is fixed here so every build shares the same enum.
package rf_master_pkg;

   localparam int DEF_ADDR_WIDTH = 3;
   localparam int DEF_RF_DEPTH   = 8;
   localparam int DEF_RF_WIDTH   = 16;

   localparam logic CMD_READ  = 1'b0;
   localparam logic CMD_WRITE = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      CAPTURE,
      VERIFY_RD,
      VERIFY_CMP,
      RESP
   } state_e;

endpackage

// File: rtl/rf_access_master.sv
// Command-driven initiator for the single-port register file: one command in flight,
// one response per command. Optional write read-back check via RF_MASTER_WRVERIFY_EN.
module rf_access_master
   import rf_master_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int RF_DEPTH   = DEF_RF_DEPTH,
   parameter int RF_WIDTH   = DEF_RF_WIDTH
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [RF_WIDTH-1:0]   cmd_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic                  rsp_write,
   output logic [RF_WIDTH-1:0]   rsp_rdata,
   output logic                  rsp_error,
   output logic                  write_enable,
   output logic                  read_enable,
   output logic [ADDR_WIDTH-1:0] address,
   output logic [RF_WIDTH-1:0]   write_data,
   input  logic [RF_WIDTH-1:0]   read_data,
   output logic                  busy
);

   state_e                state_q, state_d;
   logic                  write_q, write_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [RF_WIDTH-1:0]   wdata_q, wdata_d;
   logic [RF_WIDTH-1:0]   rdata_q, rdata_d;
   logic                  err_q, err_d;
   logic                  we_q, we_d;
   logic                  re_q, re_d;
   logic                  addr_ok;

   assign addr_ok = (int'(cmd_addr) < RF_DEPTH);

   // Strobes are computed for the state being entered so they appear as flops
   // exactly in ISSUE / VERIFY_RD and clear asynchronously on reset.
   always_comb begin
      state_d = state_q;
      write_d = write_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      we_d    = 1'b0;
      re_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               write_d = cmd_write;
               addr_d  = cmd_addr;
               wdata_d = cmd_wdata;
               rdata_d = '0;
               err_d   = !addr_ok;
               state_d = ISSUE;
               if (addr_ok) begin
                  we_d = (cmd_write == CMD_WRITE);
                  re_d = (cmd_write == CMD_READ);
               end
            end
         end
         ISSUE: begin
            if (err_q) begin
               state_d = RESP;
            end else if (write_q == CMD_WRITE) begin
`ifdef RF_MASTER_WRVERIFY_EN
               state_d = VERIFY_RD;
               re_d    = 1'b1;
`else
               state_d = RESP;
`endif
            end else begin
               state_d = CAPTURE;
            end
         end
         CAPTURE: begin
            rdata_d = read_data;
            state_d = RESP;
         end
`ifdef RF_MASTER_WRVERIFY_EN
         VERIFY_RD: begin
            state_d = VERIFY_CMP;
         end
         VERIFY_CMP: begin
            // Read-back data is compared but never returned; writes answer with rdata 0.
            if (read_data != wdata_q) err_d = 1'b1;
            state_d = RESP;
         end
`endif
         RESP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= IDLE;
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         we_q    <= 1'b0;
         re_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         write_q <= write_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         we_q    <= we_d;
         re_q    <= re_d;
      end
   end

   assign cmd_ready    = (state_q == IDLE);
   assign busy         = (state_q != IDLE);
   assign rsp_valid    = (state_q == RESP);
   assign rsp_write    = write_q;
   assign rsp_rdata    = rdata_q;
   assign rsp_error    = err_q;
   assign write_enable = we_q;
   assign read_enable  = re_q;
   assign address      = addr_q;
   assign write_data   = wdata_q;

endmodule

// File: tb/tb_rf_access_master.sv
// Scoreboard bench for rf_access_master with a behavioural 8x16 register file.
// Expectations adapt to RF_MASTER_WRVERIFY_EN.
module tb_rf_access_master;

`ifdef RF_MASTER_WRVERIFY_EN
   localparam int   WR_LAT = 4;
   localparam logic VERIFY = 1'b1;
`else
   localparam int   WR_LAT = 2;
   localparam logic VERIFY = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   always #5 CLK = ~CLK;

   logic        cmd_valid, cmd_ready, cmd_write;
   logic [2:0]  cmd_addr;
   logic [15:0] cmd_wdata;
   logic        rsp_valid, rsp_ready, rsp_write, rsp_error;
   logic [15:0] rsp_rdata;
   logic        write_enable, read_enable, busy;
   logic [2:0]  address;
   logic [15:0] write_data, read_data;

   logic        c6_valid, c6_ready, c6_write;
   logic [2:0]  c6_addr;
   logic [15:0] c6_wdata;
   logic        r6_valid, r6_write, r6_error;
   logic        r6_ready = 1'b1;
   logic [15:0] r6_rdata;
   logic        we6, re6, busy6;
   logic [2:0]  addr6;
   logic [15:0] wd6;
   logic [15:0] rd6 = 16'hFFFF;

   rf_access_master dut (
      .CLK(CLK), .RST(RST),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
      .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
      .write_enable(write_enable), .read_enable(read_enable),
      .address(address), .write_data(write_data), .read_data(read_data),
      .busy(busy)
   );

   rf_access_master #(.RF_DEPTH(6)) dut6 (
      .CLK(CLK), .RST(RST),
      .cmd_valid(c6_valid), .cmd_ready(c6_ready), .cmd_write(c6_write),
      .cmd_addr(c6_addr), .cmd_wdata(c6_wdata),
      .rsp_valid(r6_valid), .rsp_ready(r6_ready), .rsp_write(r6_write),
      .rsp_rdata(r6_rdata), .rsp_error(r6_error),
      .write_enable(we6), .read_enable(re6),
      .address(addr6), .write_data(wd6), .read_data(rd6),
      .busy(busy6)
   );

   // Register file model: registered read, both strobes together are ignored.
   logic [15:0] mem [8] = '{default: 16'h0000};
   logic [15:0] rd_q = 16'h0000;
   logic        force_zero = 1'b0;
   always @(posedge CLK) begin
      if (write_enable && !read_enable) mem[address] <= write_data;
      if (read_enable && !write_enable) rd_q <= mem[address];
   end
   assign read_data = force_zero ? 16'h0000 : rd_q;

   typedef struct packed {
      logic        w;
      logic [15:0] rdata;
      logic        err;
   } rsp_t;

   rsp_t exp_q[$];
   rsp_t exp6_q[$];
   rsp_t mon_e, mon6_e;
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Strobe tracker
   int         cyc_n = 0, we_cnt = 0, re_cnt = 0, both_cnt = 0, s6_cnt = 0;
   int         we_cyc = 0, re_cyc = 0;
   logic [2:0] we_addr = 3'd0, re_addr = 3'd0;
   logic [15:0] we_data = 16'h0;
   always @(negedge CLK) begin
      cyc_n++;
      if (write_enable && read_enable) both_cnt++;
      if (write_enable) begin
         we_cnt++; we_cyc = cyc_n; we_addr = address; we_data = write_data;
      end
      if (read_enable) begin
         re_cnt++; re_cyc = cyc_n; re_addr = address;
      end
      if (we6 || re6) s6_cnt++;
   end

   // Response monitors
   always @(negedge CLK) begin
      if (RST && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_rsp: got rdata %0h with no expected entry", rsp_rdata);
         end else begin
            mon_e = exp_q.pop_front();
            chk("rsp_write", {31'd0, rsp_write}, {31'd0, mon_e.w});
            chk("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, mon_e.rdata});
            chk("rsp_error", {31'd0, rsp_error}, {31'd0, mon_e.err});
         end
      end
      if (RST && r6_valid && r6_ready) begin
         if (exp6_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_rsp6: got rdata %0h with no expected entry", r6_rdata);
         end else begin
            mon6_e = exp6_q.pop_front();
            chk("rsp6_write", {31'd0, r6_write}, {31'd0, mon6_e.w});
            chk("rsp6_rdata", {16'd0, r6_rdata}, {16'd0, mon6_e.rdata});
            chk("rsp6_error", {31'd0, r6_error}, {31'd0, mon6_e.err});
         end
      end
   end

   task automatic present(input logic w, input logic [2:0] a, input logic [15:0] d,
                          input logic [15:0] er, input logic ee);
      rsp_t e;
      e.w = w; e.rdata = er; e.err = ee;
      cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
      exp_q.push_back(e);
   endtask

   task automatic wait_accept(output int waited);
      waited = 0;
      forever begin
         @(negedge CLK);
         if (cmd_ready) break;
         waited++;
         if (waited > 50) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got no accept expected accept within 50 cycles");
            break;
         end
      end
      @(posedge CLK); #1;
      cmd_valid = 1'b0;
   endtask

   // Waits for rsp_valid (checking latency), optionally stalls, and returns at the
   // negedge preceding the response handshake edge.
   task automatic wait_resp(input int exp_lat, input int hold, input logic nxt,
                            input logic nw, input logic [2:0] na, input logic [15:0] nd,
                            input logic [15:0] ner, input logic nee);
      int cyc = 0;
      logic [17:0] snap;
      do begin
         @(negedge CLK);
         cyc++;
      end while (!rsp_valid && cyc < 20);
      chk("latency", cyc, exp_lat);
      if (hold > 0) begin
         snap = {rsp_write, rsp_rdata, rsp_error};
         if (nxt) present(nw, na, nd, ner, nee);
         for (int i = 0; i < hold; i++) begin
            chk("stall_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            chk("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("stall_rsp_hold", {14'd0, rsp_write, rsp_rdata, rsp_error}, {14'd0, snap});
            @(negedge CLK);
         end
         @(posedge CLK); #1;
         rsp_ready = 1'b1;
         @(negedge CLK);
      end
   endtask

   task automatic do_cmd(input logic w, input logic [2:0] a, input logic [15:0] d,
                         input logic [15:0] er, input logic ee, input int lat,
                         input int exp_we, input int exp_re);
      int waited;
      int we0, re0;
      @(posedge CLK); #1;
      we0 = we_cnt; re0 = re_cnt;
      rsp_ready = 1'b1;
      present(w, a, d, er, ee);
      wait_accept(waited);
      wait_resp(lat, 0, 1'b0, 1'b0, 3'd0, 16'd0, 16'd0, 1'b0);
      chk("we_pulses", we_cnt - we0, exp_we);
      chk("re_pulses", re_cnt - re0, exp_re);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion expected finish before 500us");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1);
   end

   initial begin
      int waited, cyc, s0;
      rsp_t e6;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 3'd0; cmd_wdata = 16'd0;
      rsp_ready = 1'b1;
      c6_valid = 1'b0; c6_write = 1'b0; c6_addr = 3'd0; c6_wdata = 16'd0;

      // Reset state
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_we", {31'd0, write_enable}, 32'd0);
      chk("rst_re", {31'd0, read_enable}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
      chk("rst_rsp_error", {31'd0, rsp_error}, 32'd0);
      chk("rst_address", {29'd0, address}, 32'd0);
      @(negedge CLK);
      RST = 1'b1;

      // Write then read back
      do_cmd(1'b1, 3'd3, 16'hA5A5, 16'h0000, 1'b0, WR_LAT, 1, int'(VERIFY));
      chk("we_addr", {29'd0, we_addr}, 32'd3);
      chk("we_data", {16'd0, we_data}, 32'hA5A5);
      do_cmd(1'b0, 3'd3, 16'h0000, 16'hA5A5, 1'b0, 3, 0, 1);
      do_cmd(1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0, 3, 0, 1);
      do_cmd(1'b1, 3'd7, 16'hFFFF, 16'h0000, 1'b0, WR_LAT, 1, int'(VERIFY));
      do_cmd(1'b0, 3'd7, 16'h0000, 16'hFFFF, 1'b0, 3, 0, 1);

      // Stalled response with the next command already waiting
      @(posedge CLK); #1;
      rsp_ready = 1'b0;
      present(1'b1, 3'd1, 16'h5A5A, 16'h0000, 1'b0);
      wait_accept(waited);
      wait_resp(WR_LAT, 5, 1'b1, 1'b0, 3'd1, 16'h0000, 16'h5A5A, 1'b0);
      wait_accept(waited);
      chk("b2b_accept_gap", waited, 0);
      wait_resp(3, 0, 1'b0, 1'b0, 3'd0, 16'd0, 16'd0, 1'b0);

      // Illegal address on the 6-deep instance
      @(posedge CLK); #1;
      s0 = s6_cnt;
      e6.w = 1'b0; e6.rdata = 16'h0000; e6.err = 1'b1;
      exp6_q.push_back(e6);
      c6_write = 1'b0; c6_addr = 3'd7; c6_wdata = 16'hBEEF; c6_valid = 1'b1;
      @(negedge CLK);
      chk("d6_ready", {31'd0, c6_ready}, 32'd1);
      @(posedge CLK); #1;
      c6_valid = 1'b0;
      cyc = 0;
      do begin
         @(negedge CLK);
         cyc++;
      end while (!r6_valid && cyc < 20);
      chk("d6_latency", cyc, 2);
      chk("d6_no_strobe", s6_cnt - s0, 0);

      // Reset during ISSUE of a write: strobe drops, write abandoned
      @(posedge CLK); #1;
      cmd_write = 1'b1; cmd_addr = 3'd3; cmd_wdata = 16'hDEAD; cmd_valid = 1'b1;
      wait_accept(waited);
      @(negedge CLK);
      chk("abort_we_seen", {31'd0, write_enable}, 32'd1);
      RST = 1'b0;
      #1;
      chk("abort_we_async", {31'd0, write_enable}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      @(negedge CLK);
      RST = 1'b1;

      // Reset during CAPTURE of a read
      @(posedge CLK); #1;
      cmd_write = 1'b0; cmd_addr = 3'd3; cmd_valid = 1'b1;
      wait_accept(waited);
      @(negedge CLK);
      chk("cap_issue_re", {31'd0, read_enable}, 32'd1);
      @(negedge CLK);
      chk("cap_busy", {31'd0, busy}, 32'd1);
      RST = 1'b0;
      #1;
      chk("cap_rst_we", {31'd0, write_enable}, 32'd0);
      chk("cap_rst_re", {31'd0, read_enable}, 32'd0);
      chk("cap_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("cap_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      @(negedge CLK);
      RST = 1'b1;
      do_cmd(1'b0, 3'd3, 16'h0000, 16'hA5A5, 1'b0, 3, 0, 1);

      // Write with verify read-back
      do_cmd(1'b1, 3'd5, 16'h1234, 16'h0000, 1'b0, WR_LAT, 1, int'(VERIFY));
`ifdef RF_MASTER_WRVERIFY_EN
      chk("verify_re_follows", re_cyc, we_cyc + 1);
      chk("verify_re_addr", {29'd0, re_addr}, 32'd5);
`endif
      // Corrupted read-back only matters when verify is compiled in
      force_zero = 1'b1;
      do_cmd(1'b1, 3'd6, 16'h4321, 16'h0000, VERIFY, WR_LAT, 1, int'(VERIFY));
      force_zero = 1'b0;
      do_cmd(1'b0, 3'd6, 16'h0000, 16'h4321, 1'b0, 3, 0, 1);

      @(negedge CLK);
      chk("never_both_strobes", both_cnt, 0);
      chk("exp_q_drained", exp_q.size(), 0);
      chk("exp6_q_drained", exp6_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
